product_accumulator: RTL
========================

Name: product_accumulator

Overview:
- Downstream stage of signed_multiplier. Consumes its 8-bit two's-complement product stream through a valid/ready handshake.
- Sums COUNT consecutive products into a saturating signed accumulator, then presents one frame sum with valid/ready handshake and a sticky overflow flag.
- Forms the accumulate half of the lab's multiply-accumulate datapath: the 4x4 signed multiplier feeds prod_in directly.

Parameters:
- PROD_W, 8, width of the signed product input. Matches the multiplier's result_out.
- ACC_W, 12, width of the signed accumulator and sum_out. Must satisfy ACC_W >= PROD_W.
- COUNT, 4, number of products summed per frame. Must be >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- clear_in  input  1  synchronous frame flush. Lower priority than rst.
- prod_in  input  PROD_W  signed product from signed_multiplier.
- prod_valid_in  input  1  prod_in valid.
- prod_ready_out  output  1  block can accept prod_in.
- sum_out  output  ACC_W  signed frame sum.
- sum_valid_out  output  1  sum_out valid.
- sum_ready_in  input  1  consumer accepts sum_out.
- overflow_out  output  1  saturation occurred in the frame currently presented.

Behaviour:
- States: ACCUM and HOLD.
- Reset (rst=1 at a clock edge):
  - state=ACCUM, acc=0, cnt=0, ovf=0.
  - sum_out=0, sum_valid_out=0, overflow_out=0, prod_ready_out=1 from the following cycle.
- ACCUM state:
  - prod_ready_out=1, sum_valid_out=0.
  - A product is accepted only on a cycle where prod_valid_in=1 and prod_ready_out=1.
  - On accept: prod_in is sign-extended to ACC_W+1 bits and added to acc.
  - The result saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. If saturation happens, ovf is set and stays set (sticky) until the frame ends.
  - On accept, cnt increments.
- Frame completion:
  - Triggered when a product is accepted with cnt==COUNT-1.
  - On that edge: sum_out <= saturated(acc+prod_in), overflow_out <= ovf | saturation of this add, sum_valid_out <= 1, state <= HOLD.
  - Latency: sum_valid_out goes high in the cycle after the COUNT-th accepted product.
- HOLD state:
  - prod_ready_out=0. No products are accepted, even if prod_valid_in=1.
  - sum_out, overflow_out and sum_valid_out hold stable until sum_ready_in=1.
  - On sum_valid_out & sum_ready_in: acc=0, cnt=0, ovf=0, sum_valid_out=0, state=ACCUM.
  - overflow_out and sum_out keep their last values until the next frame completes.
  - The first product of the next frame can be accepted in the cycle after the handshake. Sustained throughput is therefore COUNT+1 cycles per frame.
- Output rules:
  - prod_ready_out is a registered state decode only. It does not depend combinationally on any input.
  - sum_valid_out never drops without a handshake, except on rst or clear_in.
- clear_in=1 (any state):
  - acc=0, cnt=0, ovf=0, sum_valid_out=0, overflow_out=0, state=ACCUM.
  - A product presented in the same cycle is discarded.
  - sum_out is left unchanged.
- rst or clear_in asserted mid-frame: the partial sum is discarded with no output. The next frame starts counting from product 1.
- Width/arithmetic rules:
  - All arithmetic is signed two's complement.
  - Internal adder width is ACC_W+1 so that saturation can be detected.
  - With the defaults, no overflow is possible: |product| <= 64 and 4*64 < 2047.

Test Plan:
- Reset, then frame of products 0x00, 0x03, 0x0A, 0xE4 (0, 3, 10, -28), sum_ready_in=1:
  - sum_out=12'hFF1 (-15), sum_valid_out=1 for exactly one cycle, overflow_out=0.
  - prod_ready_out=0 during that cycle.
- Backpressure: same frame with sum_ready_in=0 for 5 cycles and prod_valid_in held at 1 with 0x01:
  - sum_out holds at 12'hFF1 and prod_ready_out=0 throughout.
  - After sum_ready_in=1, the next frame's first accepted product is 0x01.
- Saturation with ACC_W=8, COUNT=4:
  - Products 0x40 x4 -> sum_out=8'h7F, overflow_out=1.
  - Products 0xC8 x4 (-56) -> sum_out=8'h80, overflow_out=1.
  - The following non-saturating frame (0x01 x4) -> sum_out=8'h04, overflow_out=0.
- Bubbles: prod_valid_in toggles 1,0,0,1,0,1,1 carrying 0x02, 0x05, 0xFF, 0x10:
  - sum_out=12'h016 (22) is presented only after the 4th valid product.
- Mid-frame flush: accept 0x7F, 0x7F, then clear_in=1 together with prod_valid_in=1 and 0x7F, then frame 0x01, 0x01, 0x01, 0x01:
  - No sum appears for the flushed frame.
  - Next sum_out=12'h004.
- rst asserted in HOLD with sum_valid_out=1:
  - The next cycle shows sum_valid_out=0, sum_out=0, overflow_out=0, prod_ready_out=1.

Source files
------------

// File: rtl/product_accumulator.sv
// Frame accumulator behind signed_multiplier: sums COUNT signed products with
// saturation and presents each frame sum through a valid/ready handshake.
module product_accumulator #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 12,
    parameter int COUNT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_in,
    input  logic [PROD_W-1:0] prod_in,
    input  logic              prod_valid_in,
    output logic              prod_ready_out,
    output logic [ACC_W-1:0]  sum_out,
    output logic              sum_valid_out,
    input  logic              sum_ready_in,
    output logic              overflow_out
);

    localparam int               CNT_W    = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);
    localparam logic [ACC_W-1:0] SAT_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic             sum_ovf_q, sum_ovf_d;

    logic [ACC_W:0]   sum_wide;
    logic             add_ovf;
    logic [ACC_W-1:0] add_sat;
    logic             accept;
    logic             frame_done;
    logic             handshake;

    // One guard bit: the top two bits of the wide sum disagree exactly when
    // the true result falls outside the ACC_W-bit signed range.
    assign sum_wide   = {acc_q[ACC_W-1], acc_q}
                      + {{(ACC_W+1-PROD_W){prod_in[PROD_W-1]}}, prod_in};
    assign add_ovf    = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    assign add_sat    = add_ovf ? (sum_wide[ACC_W] ? SAT_MIN : SAT_MAX)
                                : sum_wide[ACC_W-1:0];

    assign accept     = (state_q == ACCUM) && prod_valid_in;
    assign frame_done = accept && (cnt_q == CNT_LAST);
    assign handshake  = (state_q == HOLD) && sum_ready_in;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned,
        // which would infer a latch.
        state_d = state_q;
        if (clear_in) begin
            state_d = ACCUM;
        end else begin
            case (state_q)
                ACCUM:   if (frame_done)   state_d = HOLD;
                HOLD:    if (sum_ready_in) state_d = ACCUM;
                default: state_d = ACCUM;
            endcase
        end
    end

    // Outputs are pure decodes of registered state.
    always_comb begin
        prod_ready_out = (state_q == ACCUM);
        sum_valid_out  = (state_q == HOLD);
        sum_out        = sum_q;
        overflow_out   = sum_ovf_q;
    end

    // Datapath next-state: clear_in discards the partial frame but keeps sum_out.
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        sum_d     = sum_q;
        sum_ovf_d = sum_ovf_q;
        if (clear_in) begin
            acc_d     = '0;
            cnt_d     = '0;
            ovf_d     = 1'b0;
            sum_ovf_d = 1'b0;
        end else if (frame_done) begin
            sum_d     = add_sat;
            sum_ovf_d = ovf_q | add_ovf;
        end else if (accept) begin
            acc_d = add_sat;
            cnt_d = cnt_q + CNT_W'(1);
            ovf_d = ovf_q | add_ovf;
        end else if (handshake) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            sum_q     <= '0;
            sum_ovf_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            sum_q     <= sum_d;
            sum_ovf_q <= sum_ovf_d;
        end
    end

endmodule
